// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the iterative binary-to-BCD converter
package bin2bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    // Bits per BCD digit
    localparam int DIGIT_W = 4;

    // A digit at or above this value is corrected before the next shift
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;

    // Correction added so that doubling a digit carries at ten instead of sixteen
    localparam logic [DIGIT_W-1:0] ADJ_ADD = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// rtl/bin2bcd_seq_add3.sv - single-digit add-3 correction used before each doubling shift
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // 4-bit add with no carry out; digits 5..9 become 8..12 so the following
    // shift pushes a carry into the next digit exactly when the doubled value >= 10
    assign dout = (din >= ADJ_THRESH) ? (din + ADJ_ADD) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble converter, one input bit per clock, with overflow flag
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4,
    parameter int CNT_W  = $clog2(BIN_W + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BIN_W-1:0]            value,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int TOT_W = BCD_W + BIN_W;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   sr;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   adj;
    logic               ovf_acc;
    logic [TOT_W-1:0]   cat;
    logic [TOT_W-1:0]   shifted;

    // Per-digit correction of the working digits ahead of the shift
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_add3 u_add3 (
            .din  (work[i*DIGIT_W +: DIGIT_W]),
            .dout (adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected digits and remaining binary bits form one shift chain; the bit
    // leaving the top is the carry out of the most significant digit
    assign cat     = {adj, sr};
    assign shifted = {cat[TOT_W-2:0], 1'b0};

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            sr       <= '0;
            work     <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr      <= value;
                        work    <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    work    <= shifted[TOT_W-1:BIN_W];
                    sr      <= shifted[BIN_W-1:0];
                    ovf_acc <= ovf_acc | cat[TOT_W-1];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    bcd      <= work;
                    overflow <= ovf_acc;
                    done     <= 1'b1;
                    if (start) begin
                        sr      <= value;
                        work    <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
